output_port_cluster_rr: RTL
===========================

# output_port_cluster_rr

Parametrised output-port cluster for a leaf interface: NUM_OUT_PORTS independent user output channels, each with its own FIFO, destination registers, credit (freespace) counter and destination write-address counter, merged onto one network output by a round-robin arbiter. Single clock domain. Sits between the user operator's output streams and the leaf-side network injection point. It supersedes one-port-per-instance clusters: any channel count, FIFO depth and credit width, fair arbitration, and per-port stall counters.

## Interface

- NUM_OUT_PORTS, 4: number of user output channels (1..16).
- PAYLOAD_BITS, 32: user word width.
- NUM_LEAF_BITS, 6: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: destination FIFO address width.
- FIFO_DEPTH, 16: per-port FIFO entries (power of 2, ≥2).
- CREDIT_BITS, 8: credit counter width.
- CNT_BITS, 32: stall counter width.
- PACKET_BITS, localparam: 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.
- clk  in  1  sole clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- user_din  in  NUM_OUT_PORTS*PAYLOAD_BITS  port i word at slice i.
- user_vld  in  NUM_OUT_PORTS  word valid per port.
- user_ack  out  NUM_OUT_PORTS  port FIFO not full.
- cfg_vld  in  1  config strobe.
- cfg_port  in  4  target port; ≥NUM_OUT_PORTS ignored.
- cfg_op  in  2  0=set dest (leaf,port), 1=set credit, 2=add credit, 3=clear stall counters.
- cfg_data  in  NUM_LEAF_BITS+NUM_PORT_BITS  op0: {leaf,port}; op1/op2: low CREDIT_BITS = value.
- out_data  out  PACKET_BITS  {1'b1, dst_leaf, dst_port, dst_addr, payload}.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  network accepts.
- stall_cnt  out  NUM_OUT_PORTS*CNT_BITS  per-port cycles blocked on zero credit.
- stall_any  out  1  OR of per-port blocked-this-cycle.

## Operation

- Push: port i writes when user_vld[i]&&user_ack[i]; user_ack[i] = count_i < FIFO_DEPTH (combinational from registered count).
- Port i eligible: count_i>0, credit_i>0, configured_i=1 (set by op0, cleared by reset).
- Load condition: (!out_vld || out_rdy) and ≥1 eligible. Winner = first eligible port at or after rr_ptr, modulo NUM_OUT_PORTS. On load: out_data <= {1, leaf_i, port_i, addr_i, head_i}; pop FIFO i; credit_i−1; addr_i+1 mod 2^NUM_ADDR_BITS; rr_ptr <= winner+1 mod NUM_OUT_PORTS.
- out_rdy&&out_vld with no eligible port: out_vld <= 0. out_vld=1 && !out_rdy: out_data held stable, no pop.
- op0: loads leaf/port, sets configured, resets addr_i to 0 (a same-cycle load from port i uses the old values).
- Credit update order per cycle: base = (op1 ? value : credit) ; +value if op2; −1 if port loaded; result saturates at 2^CREDIT_BITS−1, never below 0.
- Stall: port i blocked = count_i>0 && credit_i==0 && configured_i; stall_cnt_i increments when blocked, saturates at all-ones; op3 clears (clear wins over increment).
- Simultaneous push and pop on one port: count unchanged; a full FIFO stays full (ack stays 0 that cycle).

## Timing

- Reset (async assert, sync release): out_vld=0, out_data=0, user_ack=all 1, stall_cnt=0, stall_any=0, credits=0, addr=0, configured=0, rr_ptr=0, FIFOs empty. Reset mid-transfer discards all queued words and the held packet.
- Latency: word accepted at edge E appears on out_data with out_vld at edge E+1 at earliest (empty FIFO, credit>0, out idle).
- Throughput: one packet per cycle while out_rdy=1 and eligible ports exist.
- Config takes effect at the edge on which cfg_vld is sampled; eligibility uses post-edge values next cycle.
- Fairness: with k ports continuously eligible, each wins once every k loads.

## Test plan

- Reset/idle: release reset, no stimulus -> out_vld=0, user_ack=4'b1111, stall_cnt all 0 for 20 cycles.
- Single port: op0 port 2 leaf 5 dport 3, op1 credit 4, push 0xA0..0xA5 -> four packets {1,5,3,addr 0..3,A0..A3}, then stall_any=1 and stall_cnt[2] increments per cycle; op2 add 2 -> A4,A5 with addr 4,5.
- Round robin: ports 0..3 configured, credit 255, each holds 3 words, out_rdy=1 -> port order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles.
- Backpressure: out_rdy=0 for 5 cycles with packet pending -> out_data stable, no pops; FIFO fills to 16, user_ack=0, further user_vld ignored; out_rdy=1 drains all 16 in order.
- Boundaries: addr wraps 127->0; credit 255 + op2 add 10 -> 255; op1 set 3 on cycle port loads -> credit 2; op3 during block -> stall_cnt 0 then restarts.
- Reset mid-operation: assert reset with out_vld=1 and FIFOs partly full -> outputs return to reset values asynchronously; after release no stale packets appear.

Source files
------------

// File: rtl/output_port_cluster_rr.sv
// Output-port cluster: each user channel has its own FIFO, destination, credit and
// address state; one round-robin arbiter merges the channels onto the network output.
module output_port_cluster_rr #(
   parameter int unsigned NUM_OUT_PORTS = 4,
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned NUM_LEAF_BITS = 6,
   parameter int unsigned NUM_PORT_BITS = 4,
   parameter int unsigned NUM_ADDR_BITS = 7,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned CREDIT_BITS   = 8,
   parameter int unsigned CNT_BITS      = 32,
   localparam int unsigned PACKET_BITS  = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
   localparam int unsigned CFG_BITS     = NUM_LEAF_BITS + NUM_PORT_BITS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_din,
   input  logic [NUM_OUT_PORTS-1:0]          user_vld,
   output logic [NUM_OUT_PORTS-1:0]          user_ack,
   input  logic                              cfg_vld,
   input  logic [3:0]                        cfg_port,
   input  logic [1:0]                        cfg_op,
   input  logic [CFG_BITS-1:0]               cfg_data,
   output logic [PACKET_BITS-1:0]            out_data,
   output logic                              out_vld,
   input  logic                              out_rdy,
   output logic [NUM_OUT_PORTS*CNT_BITS-1:0] stall_cnt,
   output logic                              stall_any
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int unsigned SW = CREDIT_BITS + 2;
   localparam logic [SW-1:0] CRED_MAX = SW'({CREDIT_BITS{1'b1}});

   localparam logic [1:0] OP_DEST = 2'd0;
   localparam logic [1:0] OP_SET  = 2'd1;
   localparam logic [1:0] OP_ADD  = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   logic [PAYLOAD_BITS-1:0]  head   [NUM_OUT_PORTS];
   logic [NUM_LEAF_BITS-1:0] leaf_a [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dport_a[NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_a [NUM_OUT_PORTS];

   logic [NUM_OUT_PORTS-1:0] push;
   logic [NUM_OUT_PORTS-1:0] pop;
   logic [NUM_OUT_PORTS-1:0] elig;
   logic [NUM_OUT_PORTS-1:0] blocked;

   logic [PW-1:0]            rr_ptr;
   logic [PW-1:0]            win;
   logic                     win_found;
   logic                     load;
   logic [PACKET_BITS-1:0]   win_pkt;
   logic [CREDIT_BITS-1:0]   cfg_value;

   assign cfg_value = CREDIT_BITS'(cfg_data);
   assign load      = (!out_vld || out_rdy) && win_found;
   assign stall_any = |blocked;

   // Rotating priority: first eligible port at or after rr_ptr, then wrap to the low ports
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
         if (!win_found && elig[j] && (PW'(j) >= rr_ptr)) begin
            win_found = 1'b1;
            win       = PW'(j);
         end
      end
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
         if (!win_found && elig[j]) begin
            win_found = 1'b1;
            win       = PW'(j);
         end
      end
   end

   always_comb begin
      win_pkt = '0;
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
         if (PW'(j) == win) begin
            win_pkt = {1'b1, leaf_a[j], dport_a[j], addr_a[j], head[j]};
         end
      end
   end

   // Output holding register; a held packet stays put until the network takes it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         rr_ptr   <= '0;
      end else if (load) begin
         out_vld  <= 1'b1;
         out_data <= win_pkt;
         rr_ptr   <= (win == PW'(NUM_OUT_PORTS - 1)) ? '0 : win + PW'(1);
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_port
      logic [PAYLOAD_BITS-1:0]  mem [FIFO_DEPTH];
      logic [AW-1:0]            wr_ptr_q;
      logic [AW-1:0]            rd_ptr_q;
      logic [CW-1:0]            count_q;
      logic [CREDIT_BITS-1:0]   credit_q;
      logic [CREDIT_BITS-1:0]   credit_nxt;
      logic [SW-1:0]            credit_sum;
      logic [NUM_LEAF_BITS-1:0] leaf_q;
      logic [NUM_PORT_BITS-1:0] dport_q;
      logic [NUM_ADDR_BITS-1:0] addr_q;
      logic                     cfg_q;
      logic [CNT_BITS-1:0]      stall_q;
      logic                     cfg_hit;

      assign cfg_hit     = cfg_vld && (cfg_port == 4'(g));
      assign user_ack[g] = count_q < CW'(FIFO_DEPTH);
      assign push[g]     = user_vld[g] && user_ack[g];
      assign pop[g]      = load && (win == PW'(g));
      assign elig[g]     = (count_q != '0) && (credit_q != '0) && cfg_q;
      assign blocked[g]  = (count_q != '0) && (credit_q == '0) && cfg_q;
      assign head[g]     = mem[rd_ptr_q];
      assign leaf_a[g]   = leaf_q;
      assign dport_a[g]  = dport_q;
      assign addr_a[g]   = addr_q;
      assign stall_cnt[g*CNT_BITS +: CNT_BITS] = stall_q;

      // Credit: set or keep, then add, then consume; clamp to [0, max]
      always_comb begin
         credit_sum = SW'((cfg_hit && (cfg_op == OP_SET)) ? cfg_value : credit_q);
         if (cfg_hit && (cfg_op == OP_ADD)) begin
            credit_sum = credit_sum + SW'(cfg_value);
         end
         if (pop[g]) begin
            credit_sum = (credit_sum == '0) ? '0 : credit_sum - SW'(1);
         end
         credit_nxt = (credit_sum > CRED_MAX) ? '1 : CREDIT_BITS'(credit_sum);
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= '0;
            leaf_q   <= '0;
            dport_q  <= '0;
            addr_q   <= '0;
            cfg_q    <= 1'b0;
            stall_q  <= '0;
         end else begin
            if (push[g]) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop[g])  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push[g] && !pop[g]) begin
               count_q <= count_q + CW'(1);
            end else if (!push[g] && pop[g]) begin
               count_q <= count_q - CW'(1);
            end
            credit_q <= credit_nxt;
            if (cfg_hit && (cfg_op == OP_DEST)) begin
               leaf_q  <= cfg_data[CFG_BITS-1 -: NUM_LEAF_BITS];
               dport_q <= cfg_data[NUM_PORT_BITS-1:0];
               cfg_q   <= 1'b1;
               addr_q  <= '0;
            end else if (pop[g]) begin
               addr_q  <= addr_q + NUM_ADDR_BITS'(1);
            end
            if (cfg_hit && (cfg_op == OP_CLR)) begin
               stall_q <= '0;
            end else if (blocked[g] && (stall_q != '1)) begin
               stall_q <= stall_q + CNT_BITS'(1);
            end
         end
      end

      // Payload storage needs no reset; occupancy is tracked by count_q
      always_ff @(posedge clk) begin
         if (push[g]) mem[wr_ptr_q] <= user_din[g*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

endmodule
